// File: rtl/decode_issue_ctrl_pkg.sv
// decode_issue_ctrl_pkg: control encodings, opcodes and the E-stage control bundle
package decode_issue_ctrl_pkg;
  typedef enum logic {ALU_SRCA_RD1, ALU_SRCA_PC} AluSrcA_t;
  typedef enum logic {ALU_SRCB_RD2, ALU_SRCB_IMM} AluSrcB_t;
  typedef enum logic [2:0] {
    ALU_OP_ADD, ALU_OP_BRANCH, ALU_OP_ARITH_LOGIC, ALU_OP_LUI, ALU_OP_AUIPC, ALU_OP_MULDIV
  } AluOp_t;
  typedef enum logic [1:0] {RESULT_ALU, RESULT_MEM, RESULT_PC4, RESULT_CSR} ResultSrc_t;
  typedef enum logic [2:0] {
    IMMSRC_I_TYPE, IMMSRC_S_TYPE, IMMSRC_B_TYPE, IMMSRC_U_TYPE, IMMSRC_J_TYPE
  } ImmSrc_t;
  typedef enum logic {PCTARGET_PC, PCTARGET_RS1} PCTargetSrc_t;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} MduOp_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam int CNT_W = $clog2(64 + 1);
  typedef struct packed {
    AluSrcA_t     alu_src_a;
    AluSrcB_t     alu_src_b;
    AluOp_t       alu_op;
    ResultSrc_t   result_src;
    PCTargetSrc_t pc_target_src;
    logic         reg_write;
    logic         mem_write;
    logic         jump;
    logic         branch;
    logic         csr_inc;
  } ctrl_t;
endpackage

// File: rtl/decode_issue_ctrl_if.sv
// decode_issue_ctrl_if: D-side handshake and E-stage control bundle
interface decode_issue_ctrl_if;
  import decode_issue_ctrl_pkg::*;
  logic [31:0]  InstrD;
  logic         ValidD;
  logic         ReadyD;
  logic         StallE;
  logic         FlushE;
  ImmSrc_t      ImmSrcD;
  AluSrcA_t     AluSrcAE;
  AluSrcB_t     AluSrcBE;
  AluOp_t       AluOpE;
  ResultSrc_t   ResultSrcE;
  PCTargetSrc_t PCTargetSrcE;
  logic         RegWriteE;
  logic         MemWriteE;
  logic         JumpE;
  logic         BranchE;
  logic         CsrInstrIncE;
  logic         MduE;
  MduOp_t       MduOpE;
  logic         MduStartE;
  logic         MduLastE;
  logic         ValidE;
  logic         IllegalE;
  modport master (
    output InstrD, ValidD, StallE, FlushE,
    input  ReadyD, ImmSrcD, AluSrcAE, AluSrcBE, AluOpE, ResultSrcE, PCTargetSrcE,
           RegWriteE, MemWriteE, JumpE, BranchE, CsrInstrIncE,
           MduE, MduOpE, MduStartE, MduLastE, ValidE, IllegalE
  );
  modport slave (
    input  InstrD, ValidD, StallE, FlushE,
    output ReadyD, ImmSrcD, AluSrcAE, AluSrcBE, AluOpE, ResultSrcE, PCTargetSrcE,
           RegWriteE, MemWriteE, JumpE, BranchE, CsrInstrIncE,
           MduE, MduOpE, MduStartE, MduLastE, ValidE, IllegalE
  );
endinterface

// File: rtl/decode_issue_ctrl_hold.sv
// issue_hold_counter: saturating down-counter that keeps an RV32M op resident in E
module issue_hold_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign busy = cnt > W'(1);
  assign last = cnt == W'(1) && dec;
endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: D->E decode/issue stage with handshake, stall/flush and RV32M hold.
// Define KIANV_RV32M_EN to enable RV32M decode and the multi-cycle hold sequencing.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 34
) (
  input logic                clk,
  input logic                reset,
  decode_issue_ctrl_if.slave bus
);
  if (XLEN != 32 || MUL_LATENCY < 1 || MUL_LATENCY > 8 || DIV_LATENCY < 1 || DIV_LATENCY > 64) begin : g_bad_param
    $error("decode_issue_ctrl: unsupported parameter set");
  end
  ctrl_t   d, e;
  ImmSrc_t imm;
  logic    legal, is_m, ready, accept, bubble, valid_e, illegal_e;
  assign is_m = bus.InstrD[6:0] == OP_OP && bus.InstrD[31:25] == 7'b0000001;
  always_comb begin
    d = '0;
    imm = IMMSRC_I_TYPE;
    legal = bus.InstrD[1:0] == 2'b11;
    case (bus.InstrD[6:0])
      OP_LOAD:   begin d.alu_src_b = ALU_SRCB_IMM; d.result_src = RESULT_MEM; d.reg_write = 1'b1; end
      OP_STORE:  begin d.alu_src_b = ALU_SRCB_IMM; d.mem_write = 1'b1; imm = IMMSRC_S_TYPE; end
      OP_OP: begin
        d.alu_op = ALU_OP_ARITH_LOGIC;
        d.reg_write = 1'b1;
        if (is_m) begin
`ifdef KIANV_RV32M_EN
          d.alu_op = ALU_OP_MULDIV;
`else
          legal = 1'b0;
`endif
        end
      end
      OP_IMM:    begin d.alu_op = ALU_OP_ARITH_LOGIC; d.alu_src_b = ALU_SRCB_IMM; d.reg_write = 1'b1; end
      OP_JAL:    begin d.jump = 1'b1; d.result_src = RESULT_PC4; d.reg_write = 1'b1; imm = IMMSRC_J_TYPE; end
      OP_JALR:   begin d.jump = 1'b1; d.result_src = RESULT_PC4; d.pc_target_src = PCTARGET_RS1; d.reg_write = 1'b1; end
      OP_BRANCH: begin d.branch = 1'b1; d.alu_op = ALU_OP_BRANCH; imm = IMMSRC_B_TYPE; end
      OP_LUI:    begin d.alu_op = ALU_OP_LUI; d.alu_src_b = ALU_SRCB_IMM; d.reg_write = 1'b1; imm = IMMSRC_U_TYPE; end
      OP_AUIPC: begin
        d.alu_op = ALU_OP_AUIPC;
        d.alu_src_a = ALU_SRCA_PC;
        d.alu_src_b = ALU_SRCB_IMM;
        d.reg_write = 1'b1;
        imm = IMMSRC_U_TYPE;
      end
      OP_SYSTEM: begin d.result_src = RESULT_CSR; d.reg_write = 1'b1; end
      default:   legal = 1'b0;
    endcase
    if (!legal) d = '0;
    d.csr_inc = legal;
  end
  assign accept = bus.ValidD & ready & !bus.StallE & !bus.FlushE;
  assign bubble = bus.FlushE | (!bus.ValidD & ready & !bus.StallE);
  always_ff @(posedge clk)
    if (reset || bubble) begin
      e <= '0;
      valid_e <= 1'b0;
      illegal_e <= 1'b0;
    end else if (accept) begin
      e <= d;
      valid_e <= 1'b1;
      illegal_e <= !legal;
    end
  assign bus.ImmSrcD      = imm;
  assign bus.ReadyD       = ready;
  assign bus.AluSrcAE     = e.alu_src_a;
  assign bus.AluSrcBE     = e.alu_src_b;
  assign bus.AluOpE       = e.alu_op;
  assign bus.ResultSrcE   = e.result_src;
  assign bus.PCTargetSrcE = e.pc_target_src;
  assign bus.RegWriteE    = e.reg_write;
  assign bus.MemWriteE    = e.mem_write;
  assign bus.JumpE        = e.jump;
  assign bus.BranchE      = e.branch;
  assign bus.CsrInstrIncE = e.csr_inc;
  assign bus.ValidE       = valid_e;
  assign bus.IllegalE     = illegal_e;
`ifdef KIANV_RV32M_EN
  logic   mdu_d, mdu_e, start_e, busy, last;
  MduOp_t mduop_e;
  logic   unused_ok;
  assign mdu_d = legal & is_m;
  assign unused_ok = ^{bus.InstrD[24:15], bus.InstrD[11:7]};
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      mdu_e <= 1'b0;
      mduop_e <= MUL;
    end else if (accept) begin
      mdu_e <= mdu_d;
      mduop_e <= mdu_d ? MduOp_t'(bus.InstrD[14:12]) : MUL;
    end
    start_e <= !reset & accept & mdu_d;
  end
  // flush also blocks the decrement so an aborted op never reports its last cycle
  issue_hold_counter #(.W(CNT_W)) u_hold (
    .clk      (clk),
    .rst      (reset),
    .clr      (bubble | (accept & !mdu_d)),
    .load     (accept & mdu_d),
    .dec      (!bus.StallE & !bus.FlushE),
    .load_val (bus.InstrD[14] ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY)),
    .busy     (busy),
    .last     (last)
  );
  assign ready         = !busy;
  assign bus.MduE      = mdu_e;
  assign bus.MduOpE    = mduop_e;
  assign bus.MduStartE = start_e;
  assign bus.MduLastE  = last;
`else
  logic unused_ok;
  assign unused_ok     = ^{bus.InstrD[24:12], bus.InstrD[11:7]};
  assign ready         = 1'b1;
  assign bus.MduE      = 1'b0;
  assign bus.MduOpE    = MUL;
  assign bus.MduStartE = 1'b0;
  assign bus.MduLastE  = 1'b0;
`endif
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed self-checking bench for decode_issue_ctrl (either KIANV_RV32M_EN build)
module tb_decode_issue_ctrl;
  import decode_issue_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [31:0] ADD  = 32'h003100B3;
  localparam logic [31:0] SW   = 32'h00112023;
  localparam logic [31:0] LW   = 32'h00412083;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] JAL  = 32'h000000EF;
  localparam logic [31:0] JALR = 32'h00008067;
  localparam logic [31:0] LUI  = 32'h123452B7;
  localparam logic [31:0] AUIP = 32'h00000097;
  localparam logic [31:0] CSRR = 32'h300020F3;
  localparam logic [31:0] DIVI = 32'h027342B3;
  localparam logic [31:0] MULI = 32'h022080B3;
  always #5 clk = ~clk;
  decode_issue_ctrl_if bus ();
  decode_issue_ctrl #(.XLEN(32), .MUL_LATENCY(1), .DIV_LATENCY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    bus.InstrD = ADD;
    bus.ValidD = 1'b1;
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", bus.ValidE, 0);
    chk("rst_regwrite", bus.RegWriteE, 0);
    chk("rst_aluop", bus.AluOpE, 0);
    chk("rst_csrinc", bus.CsrInstrIncE, 0);
    chk("rst_illegal", bus.IllegalE, 0);
    chk("rst_ready", bus.ReadyD, 1);
    chk("rst_mdu", bus.MduE, 0);
    reset = 1'b0;
    cyc();
    chk("add_valid", bus.ValidE, 1);
    chk("add_regwrite", bus.RegWriteE, 1);
    chk("add_aluop", bus.AluOpE, ALU_OP_ARITH_LOGIC);
    chk("add_srcb", bus.AluSrcBE, ALU_SRCB_RD2);
    chk("add_illegal", bus.IllegalE, 0);
    chk("add_csrinc", bus.CsrInstrIncE, 1);
    bus.InstrD = SW;
    #1;
    chk("sw_immsrc", bus.ImmSrcD, IMMSRC_S_TYPE);
    cyc();
    chk("sw_memwrite", bus.MemWriteE, 1);
    chk("sw_regwrite", bus.RegWriteE, 0);
    chk("sw_srcb", bus.AluSrcBE, ALU_SRCB_IMM);
    bus.InstrD = LW;
    #1;
    chk("lw_immsrc", bus.ImmSrcD, IMMSRC_I_TYPE);
    cyc();
    chk("lw_result", bus.ResultSrcE, RESULT_MEM);
    chk("lw_regwrite", bus.RegWriteE, 1);
    bus.InstrD = BEQ;
    #1;
    chk("beq_immsrc", bus.ImmSrcD, IMMSRC_B_TYPE);
    cyc();
    chk("beq_branch", bus.BranchE, 1);
    chk("beq_aluop", bus.AluOpE, ALU_OP_BRANCH);
    chk("beq_regwrite", bus.RegWriteE, 0);
    bus.InstrD = JAL;
    #1;
    chk("jal_immsrc", bus.ImmSrcD, IMMSRC_J_TYPE);
    cyc();
    chk("jal_jump", bus.JumpE, 1);
    chk("jal_result", bus.ResultSrcE, RESULT_PC4);
    chk("jal_target", bus.PCTargetSrcE, PCTARGET_PC);
    bus.InstrD = JALR;
    cyc();
    chk("jalr_jump", bus.JumpE, 1);
    chk("jalr_target", bus.PCTargetSrcE, PCTARGET_RS1);
    bus.InstrD = LUI;
    #1;
    chk("lui_immsrc", bus.ImmSrcD, IMMSRC_U_TYPE);
    cyc();
    chk("lui_aluop", bus.AluOpE, ALU_OP_LUI);
    bus.InstrD = AUIP;
    cyc();
    chk("auipc_aluop", bus.AluOpE, ALU_OP_AUIPC);
    chk("auipc_srca", bus.AluSrcAE, ALU_SRCA_PC);
    bus.InstrD = CSRR;
    cyc();
    chk("csr_result", bus.ResultSrcE, RESULT_CSR);
    chk("csr_regwrite", bus.RegWriteE, 1);
    bus.InstrD = 32'h003100B0;
    cyc();
    chk("lowbits_valid", bus.ValidE, 1);
    chk("lowbits_illegal", bus.IllegalE, 1);
    chk("lowbits_regwrite", bus.RegWriteE, 0);
    chk("lowbits_csrinc", bus.CsrInstrIncE, 0);
    bus.InstrD = 32'h0000007F;
    cyc();
    chk("badop_illegal", bus.IllegalE, 1);
    chk("badop_csrinc", bus.CsrInstrIncE, 0);
    bus.ValidD = 1'b0;
    cyc();
    chk("bubble_valid", bus.ValidE, 0);
    chk("bubble_illegal", bus.IllegalE, 0);
    bus.ValidD = 1'b1;
    bus.InstrD = ADD;
    cyc();
    bus.InstrD = SW;
    bus.StallE = 1'b1;
    cyc();
    chk("stall_hold_regwrite", bus.RegWriteE, 1);
    chk("stall_hold_memwrite", bus.MemWriteE, 0);
    bus.StallE = 1'b0;
    cyc();
    chk("unstall_memwrite", bus.MemWriteE, 1);
    bus.InstrD = ADD;
    bus.StallE = 1'b1;
    bus.FlushE = 1'b1;
    cyc();
    chk("flush_stall_valid", bus.ValidE, 0);
    chk("flush_stall_memwrite", bus.MemWriteE, 0);
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;
`ifdef KIANV_RV32M_EN
    bus.InstrD = DIVI;
    cyc();
    chk("div_c1_mdu", bus.MduE, 1);
    chk("div_c1_start", bus.MduStartE, 1);
    chk("div_c1_last", bus.MduLastE, 0);
    chk("div_c1_op", bus.MduOpE, 3'b100);
    chk("div_c1_aluop", bus.AluOpE, ALU_OP_MULDIV);
    chk("div_c1_ready", bus.ReadyD, 0);
    bus.InstrD = ADD;
    cyc();
    chk("div_c2_start", bus.MduStartE, 0);
    chk("div_c2_ready", bus.ReadyD, 0);
    chk("div_c2_mdu", bus.MduE, 1);
    cyc();
    chk("div_c3_ready", bus.ReadyD, 0);
    chk("div_c3_last", bus.MduLastE, 0);
    cyc();
    chk("div_c4_ready", bus.ReadyD, 1);
    chk("div_c4_last", bus.MduLastE, 1);
    cyc();
    chk("div_c5_mdu", bus.MduE, 0);
    chk("div_c5_aluop", bus.AluOpE, ALU_OP_ARITH_LOGIC);
    chk("div_c5_last", bus.MduLastE, 0);
    bus.InstrD = DIVI;
    cyc();
    chk("sdiv_c1_start", bus.MduStartE, 1);
    bus.InstrD = ADD;
    cyc();
    bus.StallE = 1'b1;
    chk("sdiv_c2_last", bus.MduLastE, 0);
    cyc();
    bus.StallE = 1'b0;
    chk("sdiv_c3_start", bus.MduStartE, 0);
    chk("sdiv_c3_ready", bus.ReadyD, 0);
    cyc();
    chk("sdiv_c4_last", bus.MduLastE, 0);
    chk("sdiv_c4_ready", bus.ReadyD, 0);
    cyc();
    chk("sdiv_c5_last", bus.MduLastE, 1);
    chk("sdiv_c5_ready", bus.ReadyD, 1);
    cyc();
    chk("sdiv_c6_mdu", bus.MduE, 0);
    bus.InstrD = DIVI;
    cyc();
    bus.InstrD = ADD;
    cyc();
    bus.FlushE = 1'b1;
    #1;
    chk("fdiv_c2_last", bus.MduLastE, 0);
    cyc();
    bus.FlushE = 1'b0;
    chk("fdiv_c3_valid", bus.ValidE, 0);
    chk("fdiv_c3_mdu", bus.MduE, 0);
    chk("fdiv_c3_ready", bus.ReadyD, 1);
    chk("fdiv_c3_last", bus.MduLastE, 0);
    bus.InstrD = MULI;
    cyc();
    chk("mul_start", bus.MduStartE, 1);
    chk("mul_last", bus.MduLastE, 1);
    chk("mul_ready", bus.ReadyD, 1);
    chk("mul_op", bus.MduOpE, 3'b000);
    bus.InstrD = ADD;
    cyc();
    chk("mul_next_mdu", bus.MduE, 0);
    chk("mul_next_regwrite", bus.RegWriteE, 1);
`else
    bus.InstrD = MULI;
    cyc();
    chk("nom_valid", bus.ValidE, 1);
    chk("nom_illegal", bus.IllegalE, 1);
    chk("nom_regwrite", bus.RegWriteE, 0);
    chk("nom_csrinc", bus.CsrInstrIncE, 0);
    chk("nom_mdu", bus.MduE, 0);
    chk("nom_ready", bus.ReadyD, 1);
    bus.InstrD = ADD;
    cyc();
    chk("nom_next_illegal", bus.IllegalE, 0);
    chk("nom_next_ready", bus.ReadyD, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Parametrised decode-to-execute control stage for the kianv 5-stage pipeline. Decodes the D-stage instruction word into the control bundle and registers it into the E stage. It adds a valid/ready handshake, stall and flush handling, and illegal-instruction flagging. It also sequences multi-cycle RV32M operations by holding them in E for a configurable number of cycles.

## Interface
Parameters:
- XLEN, 32: datapath width; only 32 is legal, checked by elaboration assertion.
- MUL_LATENCY, 1: E-stage hold cycles for MUL/MULH/MULHSU/MULHU (funct3[2]=0); legal range 1..8.
- DIV_LATENCY, 34: E-stage hold cycles for DIV/DIVU/REM/REMU (funct3[2]=1); legal range 1..64.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- InstrD  in  32  D-stage instruction word
- ValidD  in  1  InstrD holds a real instruction
- ReadyD  out  1  block accepts InstrD this cycle
- StallE  in  1  hazard unit freezes the E register
- FlushE  in  1  hazard unit inserts a bubble into E
- ImmSrcD  out  ImmSrc_t  combinational immediate selector for the D-stage extender
- AluSrcAE, AluSrcBE, AluOpE, ResultSrcE, PCTargetSrcE  out  package types  registered control
- RegWriteE, MemWriteE, JumpE, BranchE, CsrInstrIncE  out  1  registered control
- MduE  out  1  E holds an RV32M operation
- MduOpE  out  3  funct3 of the RV32M operation
- MduStartE  out  1  pulse, first hold cycle of an RV32M operation
- MduLastE  out  1  pulse, final hold cycle of an RV32M operation
- ValidE  out  1  E holds a real instruction
- IllegalE  out  1  E instruction is illegal

## Operation
- Accept when ValidD & ReadyD & !StallE & !FlushE. The E register loads the decoded bundle and ValidE=1.
- Bubble: FlushE, or (!ValidD & ReadyD & !StallE). The E register loads all enables 0, ValidE=0, MduE=0, counter cleared.
- Priority is reset > FlushE > StallE > accept/bubble. FlushE during StallE still bubbles.
- Decode per opcode:
  - load: src B = imm, result = read data, RegWrite.
  - store: src B = imm, MemWrite.
  - R-type and I-type: AluOp = ARITH_LOGIC, RegWrite; I-type src B = imm.
  - jal: Jump, PC+4 result, PC target = PC.
  - jalr: Jump, PC+4 result, PC target = rs1.
  - branch: Branch, AluOp = BRANCH.
  - lui: AluOp = LUI.
  - auipc: AluOp = AUIPC, src A = PC.
  - system: result = CSR data, RegWrite.
  - CsrInstrIncE=1 for every legal instruction.
- R-type with funct7=0000001 is RV32M: AluOp = ALU_OP_MULDIV, MduE=1, MduOpE=funct3, RegWrite.
- Illegal: an unknown opcode, or InstrD[1:0]≠2'b11. The bundle is forced to RegWrite=MemWrite=Jump=Branch=CsrInstrInc=0, with ValidE=1 and IllegalE=1.
- RV32M hold: on accept, load hold counter N = MUL_LATENCY or DIV_LATENCY.
  - The counter decrements each cycle with !StallE.
  - ReadyD=0 while counter>1.
  - MduStartE=1 in the first hold cycle; MduLastE=1 when counter==1 and !StallE.
- ReadyD is 1 whenever no RV32M hold is in progress.

## Timing
- Reset: every E output 0, ValidE=0, IllegalE=0, ReadyD=1, counter=0.
- D→E latency is 1 cycle. ImmSrcD is combinational from InstrD with zero latency.
- With latency 1, an RV32M operation never deasserts ReadyD; start and last pulse in the same cycle.
- With latency N, ReadyD is low for N-1 cycles. The next instruction enters E in hold cycle N+1.
- StallE during a hold freezes the counter and suppresses MduLastE; MduStartE is never re-asserted.
- FlushE or reset mid-hold aborts the operation in the next cycle: counter=0, ReadyD=1, no MduLastE.
- The counter is $clog2(64+1) bits; it never wraps and saturates at 0.

## Configuration
- KIANV_RV32M_EN defined: RV32M decode, the hold counter and the Mdu* outputs are present.
- KIANV_RV32M_EN undefined:
  - funct7=0000001 R-type decodes as illegal (IllegalE=1).
  - The counter is removed.
  - MduE, MduStartE and MduLastE are tied 0; ReadyD is tied 1.

## Structure
- The shared package holds AluSrcA_t, AluSrcB_t, AluOp_t (extended with ALU_OP_MULDIV), ResultSrc_t, ImmSrc_t, PCTargetSrc_t, and the opcode constants.
- The package also holds the MduOp_t enum (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- The hold counter is one sub-module, issue_hold_counter: load, decrement enable, clear, last flag.

## Test plan
- Reset asserted 2 cycles with ValidD=1 → all E outputs 0, ReadyD=1; the first accept occurs in the cycle after reset deasserts.
- add x1,x2,x3 (0x003100B3), ValidD=1 → next cycle ValidE=1, RegWriteE=1, AluOpE=ALU_OP_ARITH_LOGIC, AluSrcBE=ALU_SRCB_RD2, IllegalE=0.
- sw x1,0(x2) (0x00112023) → ImmSrcD=IMMSRC_S_TYPE in the same cycle; next cycle MemWriteE=1, RegWriteE=0.
- div x5,x6,x7 (0x027342B3), DIV_LATENCY=4:
  - MduStartE in hold cycle 1, MduLastE in cycle 4, MduOpE=3'b100.
  - ReadyD low in cycles 1–3; the following add enters E in cycle 5.
  - A second run with StallE high in cycle 2 moves MduLastE to cycle 5.
- Same div with FlushE high in hold cycle 2 → cycle 3 has ValidE=0, MduE=0, ReadyD=1, and no MduLastE.
- KIANV_RV32M_EN undefined, mul x1,x1,x2 (0x022080B3) → ValidE=1, IllegalE=1, RegWriteE=0, CsrInstrIncE=0, ReadyD stays 1.
